// File: rtl/avg_pool_ctrl.sv
// avg_pool_ctrl
//   Sequencer for the avg_pooling multiplier array. Each pooling window
//   accumulates win_len beats of DATA_COPIES signed lanes. Each sum is
//   arithmetically shifted right and saturated to DATA_WIDTH, then presented
//   to the external multiplier together with the latched reciprocal weight.
//   The products are registered onto a valid/ready output stream. One start
//   runs num_win windows.
//
// Ports
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_start                        job start, sampled in IDLE only
//   i_cfg_win_len/num_win/recip/shift  job configuration, latched on start
//   i_in_valid, o_in_ready, i_in_data  input beat stream
//   o_mdata, o_wdata               saturated sums / reciprocal to multiplier
//   i_mul_result                   multiplier products (combinational)
//   o_out_valid, i_out_ready, o_out_data  product output stream
//   o_busy, o_done                 job status
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for i_start, config latched on start
// ACCUM | accepting beats of the current window
// MUL   | o_mdata holds saturated sums, products captured at cycle end
// OUT   | product beat presented, waiting for i_out_ready
// DONE  | one-cycle o_done pulse, then back to IDLE
module avg_pool_ctrl #(
   parameter int DATA_WIDTH  = 8,
   parameter int DATA_COPIES = 32,
   parameter int CNT_WIDTH   = 6,
   parameter int SHIFT_WIDTH = 4
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic                                i_start,
   input  logic [CNT_WIDTH-1:0]                i_cfg_win_len,
   input  logic [15:0]                         i_cfg_num_win,
   input  logic [DATA_WIDTH-1:0]               i_cfg_recip,
   input  logic [SHIFT_WIDTH-1:0]              i_cfg_shift,
   input  logic                                i_in_valid,
   output logic                                o_in_ready,
   input  logic [DATA_COPIES*DATA_WIDTH-1:0]   i_in_data,
   output logic [DATA_COPIES*DATA_WIDTH-1:0]   o_mdata,
   output logic [DATA_WIDTH-1:0]               o_wdata,
   input  logic [DATA_COPIES*2*DATA_WIDTH-1:0] i_mul_result,
   output logic                                o_out_valid,
   input  logic                                i_out_ready,
   output logic [DATA_COPIES*2*DATA_WIDTH-1:0] o_out_data,
   output logic                                o_busy,
   output logic                                o_done
);

   localparam int ACC_WIDTH = DATA_WIDTH + CNT_WIDTH;
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
   localparam logic [DATA_WIDTH-1:0] LANE_MAX = SAT_MAX[DATA_WIDTH-1:0];
   localparam logic [DATA_WIDTH-1:0] LANE_MIN = SAT_MIN[DATA_WIDTH-1:0];

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCUM,
      S_MUL,
      S_OUT,
      S_DONE
   } state_t;

   state_t                               state;
   logic [CNT_WIDTH-1:0]                 win_len_q;
   logic [SHIFT_WIDTH-1:0]               shift_q;
   logic [CNT_WIDTH-1:0]                 beat_left;
   logic [15:0]                          win_left;
   logic [DATA_COPIES*ACC_WIDTH-1:0]     acc_q;
   logic [DATA_COPIES*ACC_WIDTH-1:0]     acc_next;
   logic [DATA_COPIES*DATA_WIDTH-1:0]    mdata_next;
   logic                                 beat_fire;
   logic                                 first_beat;
   logic                                 last_beat;
   logic [CNT_WIDTH-1:0]                 win_len_eff;

   assign beat_fire   = o_in_ready & i_in_valid;
   // beat_left is reloaded with win_len at each window start, so a full
   // count means no beat of this window has been taken yet.
   assign first_beat  = (beat_left == win_len_q);
   assign last_beat   = (beat_left == CNT_WIDTH'(1));
   assign win_len_eff = (i_cfg_win_len == '0) ? CNT_WIDTH'(1) : i_cfg_win_len;

   // The sum including the current beat is saturated here, so the final
   // beat of a window can load o_mdata directly and MUL needs only one cycle.
   for (genvar g = 0; g < DATA_COPIES; g++) begin : g_lane
      logic signed [DATA_WIDTH-1:0] lane;
      logic signed [ACC_WIDTH-1:0]  ext;
      logic signed [ACC_WIDTH-1:0]  sum;
      logic signed [ACC_WIDTH-1:0]  shifted;

      assign lane    = i_in_data[g*DATA_WIDTH +: DATA_WIDTH];
      assign ext     = {{CNT_WIDTH{lane[DATA_WIDTH-1]}}, lane};
      assign sum     = first_beat ? ext : $signed(acc_q[g*ACC_WIDTH +: ACC_WIDTH]) + ext;
      assign shifted = sum >>> shift_q;
      assign acc_next[g*ACC_WIDTH +: ACC_WIDTH] = sum;
      assign mdata_next[g*DATA_WIDTH +: DATA_WIDTH] =
         (shifted > SAT_MAX) ? LANE_MAX :
         (shifted < SAT_MIN) ? LANE_MIN : shifted[DATA_WIDTH-1:0];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= S_IDLE;
         win_len_q   <= '0;
         shift_q     <= '0;
         beat_left   <= '0;
         win_left    <= '0;
         acc_q       <= '0;
         o_in_ready  <= 1'b0;
         o_mdata     <= '0;
         o_wdata     <= '0;
         o_out_valid <= 1'b0;
         o_out_data  <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (i_start) begin
                  win_len_q <= win_len_eff;
                  beat_left <= win_len_eff;
                  shift_q   <= i_cfg_shift;
                  o_wdata   <= i_cfg_recip;
                  win_left  <= i_cfg_num_win;
                  o_busy    <= 1'b1;
                  if (i_cfg_num_win == '0) begin
                     o_done <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     o_in_ready <= 1'b1;
                     state      <= S_ACCUM;
                  end
               end
            end
            S_ACCUM: begin
               if (beat_fire) begin
                  acc_q     <= acc_next;
                  beat_left <= beat_left - CNT_WIDTH'(1);
                  if (last_beat) begin
                     o_mdata    <= mdata_next;
                     o_in_ready <= 1'b0;
                     state      <= S_MUL;
                  end
               end
            end
            S_MUL: begin
               o_out_data  <= i_mul_result;
               o_out_valid <= 1'b1;
               o_mdata     <= '0;
               state       <= S_OUT;
            end
            S_OUT: begin
               if (i_out_ready) begin
                  o_out_valid <= 1'b0;
                  win_left    <= win_left - 16'd1;
                  if (win_left == 16'd1) begin
                     o_done <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     beat_left  <= win_len_q;
                     o_in_ready <= 1'b1;
                     state      <= S_ACCUM;
                  end
               end
            end
            S_DONE: begin
               o_done <= 1'b0;
               o_busy <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
